mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 64-bit, single-ported, variable-latency memory between instruction fetch (IF, read-only)
//  and data access (DM, load/store) in the multi-cycle CPU.
//  Round-robin on contention, one transaction in flight, watchdog on unresponsive memory.
//  Sits between the PC/fetch logic, the load/store datapath and the unified memory model.
// PARAMETERS
//  TIMEOUT  64  max cycles in WAIT for mem_done before the access is aborted with error
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (asserted when 0)
//  if_req     in   1   fetch request, level; held with if_addr until if_ack
//  if_addr    in   64  fetch byte address (word-aligned)
//  if_ack     out  1   one-cycle completion pulse
//  if_rdata   out  32  instruction word, valid while if_ack=1
//  if_err     out  1   timeout flag, valid while if_ack=1
//  dm_req     in   1   data request, level; held with operands until dm_ack
//  dm_we      in   1   1=store, 0=load
//  dm_addr    in   64  data byte address
//  dm_wdata   in   64  store data
//  dm_size    in   4   transfer size in bytes (1,2,4,8)
//  dm_ack     out  1   one-cycle completion pulse
//  dm_rdata   out  64  load data, valid while dm_ack=1 for loads
//  dm_err     out  1   timeout flag, valid while dm_ack=1
//  mem_en     out  1   one-cycle request strobe to memory
//  mem_we     out  1   write enable, qualified by mem_en
//  mem_addr   out  64  memory byte address, stable from mem_en until mem_done
//  mem_wdata  out  64  write data, stable like mem_addr
//  mem_size   out  4   transfer size, stable like mem_addr
//  mem_rdata  in   64  read data, valid when mem_done=1
//  mem_done   in   1   one-cycle completion from memory
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; last_grant=IF, so the first tie goes to DM.
//  - All outputs are registered.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE, edge with any req:
//    - Pick a winner: single requester wins; on a tie, the requester not equal to last_grant wins.
//    - Latch the winner's operands into mem_* and set mem_en=1. last_grant<=winner. Go to WAIT.
//  - IF access drives: mem_addr={if_addr[63:3],3'b000}, mem_we=0, mem_size=8, mem_wdata=0.
//  - DM access drives: mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata, mem_size=dm_size (passed unchecked).
//  - WAIT:
//    - mem_en=0 after its first cycle. wait_cnt counts up from 0.
//    - mem_done=1 -> go to RESP; assert ack=1, err=0 for the winner.
//      - IF: if_rdata=if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
//      - DM load: dm_rdata=mem_rdata.
//      - DM store: dm_rdata holds 0.
//    - wait_cnt==TIMEOUT-1 with no mem_done -> go to RESP; assert ack=1, err=1, rdata=0.
//    - mem_done and timeout in the same cycle: mem_done wins, err=0.
//  - RESP: ack/err/rdata return to 0; mem_* cleared to 0; next state IDLE.
//  - Requester drops req during RESP; IDLE re-samples on the next edge.
//  - Latency: req sampled at edge E; mem_en high in E..E+1; done at edge D; ack high D..D+1.
//    - Back-to-back turnaround: 3 cycles + memory latency.
//  - mem_done seen in IDLE or RESP is ignored (late completion after timeout is discarded).
//  - A request arriving while not IDLE waits; reqs must stay high until ack. Rule is asserted in bench.
//  - Reset mid-transaction: abort immediately, no ack issued, outputs to reset values.
//  - Fairness: under continuous IF+DM contention, grants alternate DM, IF, DM, IF...
//  - Never two acks in one cycle.
// STRUCTURE
//  - mem_arb_pkg: typedef enum {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t.
//  - mem_arb_pkg: typedef enum {GNT_IF, GNT_DM} arb_grant_t.
//  - mem_arb_pkg: localparam MEM_BYTES=8.
//  - Sub-module wait_counter:
//    - Parameterised TIMEOUT; clear/enable inputs; expired output.
//    - Width $clog2(TIMEOUT+1).
//    - Async active-low reset.
// TESTING
//  1 Reset with both reqs high -> all outputs 0.
//    After release: DM granted first, mem_en pulse, mem_addr=dm_addr.
//  2 IF req, if_addr=0x104; memory returns 0xAAAA_BBBB_CCCC_DDDD after 3 cycles.
//    -> mem_addr=0x100, if_rdata=0xAAAA_BBBB, if_ack one cycle.
//  3 IF and DM both held continuously for 6 transactions -> grant order DM, IF, DM, IF, DM, IF.
//  4 DM store addr=0x40, wdata=0x1234, size=8; mem_done after 1 cycle.
//    -> mem_we=1, dm_ack=1, dm_err=0, dm_rdata=0.
//  5 mem_done never asserted, TIMEOUT=64 -> dm_ack with dm_err=1 exactly 64 cycles after mem_en.
//    A later stray mem_done is ignored.
//  6 rst asserted in WAIT -> no ack. After release, a fresh IF req completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM states, grant owner,
// the latched memory request and the tie-break rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic       {GNT_IF, GNT_DM}               arb_grant_t;

    localparam int MEM_BYTES = 8;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
    } mem_req_t;

    // On a tie the side that did not win last time goes first.
    function automatic logic pick_dm(input logic if_req, input logic dm_req, input arb_grant_t last);
        return dm_req && (!if_req || last == GNT_IF);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-access and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [3:0]  dm_size;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        dm_err;

    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_size;
    logic [63:0] mem_rdata;
    logic        mem_done;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size, mem_rdata, mem_done,
        output if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_size
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size, mem_rdata, mem_done,
        input  if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_size
    );

endinterface

// File: rtl/wait_counter.sv
// Cycle counter for the memory watchdog; o_expired flags the last allowed WAIT cycle.
module wait_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    // Saturates at the expiry value so a stalled FSM can never wrap it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency 64-bit memory between
// instruction fetch and load/store, one transaction in flight, with watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t  r_state;
    arb_grant_t  r_gnt;
    arb_grant_t  r_last;
    mem_req_t    r_req;
    logic        r_mem_en;
    logic        r_if_hi;
    logic        r_if_ack;
    logic        r_if_err;
    logic [31:0] r_if_rdata;
    logic        r_dm_ack;
    logic        r_dm_err;
    logic [63:0] r_dm_rdata;

    logic        w_pick_dm;
    logic        w_in_wait;
    logic        w_expired;

    assign w_pick_dm = pick_dm(bus.if_req, bus.dm_req, r_last);
    assign w_in_wait = (r_state == ARB_WAIT);

    wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_wait),
        .i_en      (w_in_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= GNT_IF;
            r_last     <= GNT_IF;
            r_req      <= '0;
            r_mem_en   <= 1'b0;
            r_if_hi    <= 1'b0;
            r_if_ack   <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_ack   <= 1'b0;
            r_dm_err   <= 1'b0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (bus.if_req || bus.dm_req) begin
                        r_state  <= ARB_WAIT;
                        r_mem_en <= 1'b1;
                        if (w_pick_dm) begin
                            r_gnt  <= GNT_DM;
                            r_last <= GNT_DM;
                            r_req  <= '{we: bus.dm_we, addr: bus.dm_addr,
                                        wdata: bus.dm_wdata, size: bus.dm_size};
                        end else begin
                            r_gnt   <= GNT_IF;
                            r_last  <= GNT_IF;
                            r_req   <= '{we: 1'b0, addr: {bus.if_addr[63:3], 3'b000},
                                         wdata: 64'h0, size: 4'(MEM_BYTES)};
                            r_if_hi <= bus.if_addr[2];
                        end
                    end
                end
                ARB_WAIT: begin
                    r_mem_en <= 1'b0;
                    // A completion on the expiry cycle still counts as success.
                    if (bus.mem_done || w_expired) begin
                        r_state <= ARB_RESP;
                        if (r_gnt == GNT_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_err   <= !bus.mem_done;
                            r_if_rdata <= !bus.mem_done ? 32'h0 :
                                          r_if_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                        end else begin
                            r_dm_ack   <= 1'b1;
                            r_dm_err   <= !bus.mem_done;
                            r_dm_rdata <= (bus.mem_done && !r_req.we) ? bus.mem_rdata : 64'h0;
                        end
                    end
                end
                ARB_RESP: begin
                    r_state    <= ARB_IDLE;
                    r_req      <= '0;
                    r_if_ack   <= 1'b0;
                    r_if_err   <= 1'b0;
                    r_if_rdata <= '0;
                    r_dm_ack   <= 1'b0;
                    r_dm_err   <= 1'b0;
                    r_dm_rdata <= '0;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.dm_err    = r_dm_err;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_req.we;
    assign bus.mem_addr  = r_req.addr;
    assign bus.mem_wdata = r_req.wdata;
    assign bus.mem_size  = r_req.size;

endmodule
